// File: rtl/pb_pkg.sv
// Shared types and defaults for the push-button conditioner.
// Holds the arbitration state encoding and default sizing constants.
// Imported by the debounce cell and the conditioner top.
package pb_pkg;

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} pb_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int NUM_PB_DEF          = 13;

endpackage

// File: rtl/pb_conditioner_if.sv
// Button-side and keystroke-side signals of the conditioner.
// Latency: n/a (wiring only).
// Backpressure: none; all outputs are levels or single-cycle strobes.
interface pb_conditioner_if #(
  parameter int NUM_PB = 13,
  parameter int CODE_W = $clog2(NUM_PB)
);
  logic [NUM_PB-1:0] pb;
  logic [NUM_PB-1:0] pb_level;
  logic [NUM_PB-1:0] pb_strobe;
  logic [CODE_W-1:0] keycode;
  logic              key_valid;
  logic              key_multi;
  logic              busy;

  // Button source / keystroke consumer side
  modport master (
    output pb,
    input  pb_level, pb_strobe, keycode, key_valid, key_multi, busy
  );

  // Conditioner side
  modport slave (
    input  pb,
    output pb_level, pb_strobe, keycode, key_valid, key_multi, busy
  );
endinterface

// File: rtl/pb_debounce.sv
// One-bit conditioner: 2-FF synchroniser followed by a stable-count debouncer.
// Latency: new level accepted DEBOUNCE_CYCLES+2 edges after the raw change.
// Backpressure: none; free-running per clock.
module pb_debounce
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic nrst,
  input  logic pb_i,
  output logic level_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;

  // Plain two-flop synchroniser, nothing between the stages
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pb_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive mismatching cycles; any match clears the count
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter and accepted level registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/pb_conditioner.sv
// Debounces NUM_PB buttons and emits one keystroke (index + pulse) per press.
// Latency: key_valid DEBOUNCE_CYCLES+3 edges after a stable raw press.
// Backpressure: none; presses arriving while a key is held are strobed but dropped.
module pb_conditioner
  import pb_pkg::*;
#(
  parameter int NUM_PB          = NUM_PB_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           nrst,
  pb_conditioner_if.slave bus
);

  localparam int CODE_W = $clog2(NUM_PB);

  logic [NUM_PB-1:0] level;
  logic [NUM_PB-1:0] level_q;
  logic [NUM_PB-1:0] rise;
  logic [NUM_PB-1:0] strobe_q;
  logic [CODE_W-1:0] low_idx;
  logic              multi;

  pb_state_t         state_q;
  pb_state_t         state_d;
  logic [CODE_W-1:0] keycode_q;
  logic [CODE_W-1:0] keycode_d;
  logic              valid_q;
  logic              valid_d;
  logic              multi_q;
  logic              multi_d;
  logic              busy_q;

  for (genvar g = 0; g < NUM_PB; g++) begin : g_db
    pb_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .nrst   (nrst),
      .pb_i   (bus.pb[g]),
      .level_o(level[g])
    );
  end

  assign rise  = level & ~level_q;
  assign multi = ($countones(rise) > 1);

  // Priority encoder: lowest set index of the rising-edge vector wins
  always_comb begin
    low_idx = '0;
    for (int i = NUM_PB - 1; i >= 0; i--) begin
      if (rise[i]) low_idx = CODE_W'(i);
    end
  end

  // Previous-level and strobe registers for edge detection
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      level_q  <= '0;
      strobe_q <= '0;
    end else begin
      level_q  <= level;
      strobe_q <= rise;
    end
  end

  // Arbitration: accept only when idle, lock out until every key is released
  always_comb begin
    state_d   = state_q;
    keycode_d = keycode_q;
    valid_d   = 1'b0;
    multi_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise != '0) begin
          keycode_d = low_idx;
          valid_d   = 1'b1;
          multi_d   = multi;
          state_d   = HELD;
        end
      end
      HELD: begin
        if (level == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and keystroke output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      keycode_q <= '0;
      valid_q   <= 1'b0;
      multi_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      keycode_q <= keycode_d;
      valid_q   <= valid_d;
      multi_q   <= multi_d;
      busy_q    <= (state_d == HELD);
    end
  end

  assign bus.pb_level  = level;
  assign bus.pb_strobe = strobe_q;
  assign bus.keycode   = keycode_q;
  assign bus.key_valid = valid_q;
  assign bus.key_multi = multi_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner with DEBOUNCE_CYCLES=4, NUM_PB=13.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
// Expected values are hand-derived edge counts from the raw input change.
module tb_pb_conditioner;
  import pb_pkg::*;

  localparam int NPB = 13;
  localparam int DBC = 4;

  logic clk;
  logic nrst;
  int   n_checks;
  int   n_fail;

  pb_conditioner_if #(.NUM_PB(NPB)) pbif ();

  pb_conditioner #(
    .NUM_PB         (NPB),
    .DEBOUNCE_CYCLES(DBC)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (pbif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".level"},  32'(pbif.pb_level),  32'h0);
    check({tag, ".strobe"}, 32'(pbif.pb_strobe), 32'h0);
    check({tag, ".keycode"}, 32'(pbif.keycode),  32'h0);
    check({tag, ".valid"},  32'(pbif.key_valid), 32'h0);
    check({tag, ".multi"},  32'(pbif.key_multi), 32'h0);
    check({tag, ".busy"},   32'(pbif.busy),      32'h0);
  endtask

  initial begin
    int vcnt;
    logic [NPB-1:0] acc_lvl;
    logic [NPB-1:0] acc_stb;
    int v_cyc[$];
    logic released;
    logic repressed;

    n_checks = 0;
    n_fail   = 0;
    nrst     = 1'b0;
    pbif.pb  = '0;

    // ---- reset state ----
    #1;
    check_all_zero("rst0");
    tick(2);
    nrst = 1'b1;
    tick(2);

    // ---- 1. reset mid-press ----
    pbif.pb[3] = 1'b1;
    tick(5);
    nrst = 1'b0;
    #1;
    check_all_zero("rst_mid");
    tick(1);
    nrst = 1'b1;
    tick(5);                       // after edge 4 since release
    check("t1.level_e4", 32'(pbif.pb_level[3]), 32'd0);
    tick(1);                       // edge 5
    check("t1.level_e5", 32'(pbif.pb_level[3]), 32'd1);
    check("t1.valid_e5", 32'(pbif.key_valid), 32'd0);
    tick(1);                       // edge 6
    check("t1.valid_e6", 32'(pbif.key_valid), 32'd1);
    check("t1.code_e6",  32'(pbif.keycode),   32'd3);
    pbif.pb[3] = 1'b0;
    tick(10);
    check("t1.busy_idle", 32'(pbif.busy), 32'd0);

    // ---- 2. clean press ----
    pbif.pb[3] = 1'b1;
    tick(5);                       // edge 4
    check("t2.level_e4", 32'(pbif.pb_level), 32'h0);
    tick(1);                       // edge 5
    check("t2.level_e5",  32'(pbif.pb_level),  32'h0008);
    check("t2.strobe_e5", 32'(pbif.pb_strobe), 32'h0);
    check("t2.valid_e5",  32'(pbif.key_valid), 32'd0);
    tick(1);                       // edge 6
    check("t2.strobe_e6", 32'(pbif.pb_strobe), 32'h0008);
    check("t2.valid_e6",  32'(pbif.key_valid), 32'd1);
    check("t2.code_e6",   32'(pbif.keycode),   32'd3);
    check("t2.multi_e6",  32'(pbif.key_multi), 32'd0);
    check("t2.busy_e6",   32'(pbif.busy),      32'd1);
    tick(1);                       // edge 7
    check("t2.strobe_e7", 32'(pbif.pb_strobe), 32'h0);
    check("t2.valid_e7",  32'(pbif.key_valid), 32'd0);
    check("t2.code_e7",   32'(pbif.keycode),   32'd3);
    tick(12);
    pbif.pb[3] = 1'b0;
    tick(5);                       // edge 4 after release
    check("t2.rel_level_e4", 32'(pbif.pb_level[3]), 32'd1);
    check("t2.rel_busy_e4",  32'(pbif.busy),        32'd1);
    tick(1);                       // edge 5
    check("t2.rel_level_e5", 32'(pbif.pb_level[3]), 32'd0);
    check("t2.rel_strobe",   32'(pbif.pb_strobe),   32'h0);
    tick(1);                       // edge 6
    check("t2.rel_busy_e6",  32'(pbif.busy),        32'd0);
    tick(3);

    // ---- 3. glitch ----
    acc_lvl = '0;
    acc_stb = '0;
    vcnt    = 0;
    pbif.pb[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 3) pbif.pb[0] = 1'b0;
      tick(1);
      acc_lvl |= pbif.pb_level;
      acc_stb |= pbif.pb_strobe;
      if (pbif.key_valid) vcnt++;
    end
    check("t3.level",  32'(acc_lvl), 32'h0);
    check("t3.strobe", 32'(acc_stb), 32'h0);
    check("t3.valid",  vcnt,         32'd0);

    // ---- 4. bounce ----
    vcnt = 0;
    for (int c = 0; c < 12; c++) begin
      pbif.pb[5] = ((c / 2) % 2 == 0);
      tick(1);
      if (pbif.key_valid) vcnt++;
    end
    pbif.pb[5] = 1'b1;             // final rising transition
    tick(6);                       // edge 5
    check("t4.valid_e5", 32'(pbif.key_valid), 32'd0);
    if (pbif.key_valid) vcnt++;
    tick(1);                       // edge 6
    check("t4.valid_e6", 32'(pbif.key_valid), 32'd1);
    check("t4.code",     32'(pbif.keycode),   32'd5);
    if (pbif.key_valid) vcnt++;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      if (pbif.key_valid) vcnt++;
    end
    check("t4.count", vcnt, 32'd1);
    pbif.pb[5] = 1'b0;
    tick(10);
    check("t4.busy_idle", 32'(pbif.busy), 32'd0);

    // ---- 5. simultaneous keys and lockout ----
    pbif.pb[12] = 1'b1;
    pbif.pb[10] = 1'b1;
    tick(7);                       // edge 6
    check("t5.valid",  32'(pbif.key_valid), 32'd1);
    check("t5.code",   32'(pbif.keycode),   32'd10);
    check("t5.multi",  32'(pbif.key_multi), 32'd1);
    check("t5.strobe", 32'(pbif.pb_strobe), 32'h1400);
    tick(3);
    vcnt = 0;
    pbif.pb[11] = 1'b1;
    tick(7);                       // edge 6 for key 11
    check("t5.strobe11", 32'(pbif.pb_strobe), 32'h0800);
    check("t5.lock_valid", 32'(pbif.key_valid), 32'd0);
    check("t5.lock_code",  32'(pbif.keycode),   32'd10);
    check("t5.lock_busy",  32'(pbif.busy),      32'd1);
    for (int c = 0; c < 5; c++) begin
      tick(1);
      if (pbif.key_valid) vcnt++;
    end
    check("t5.lock_count", vcnt, 32'd0);
    pbif.pb = '0;
    tick(7);                       // edge 6 after release
    check("t5.busy_rel", 32'(pbif.busy),     32'd0);
    check("t5.level_rel", 32'(pbif.pb_level), 32'h0);
    tick(3);

    // ---- 6. re-press after release ----
    released  = 1'b0;
    repressed = 1'b0;
    pbif.pb[1] = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick(1);
      if (pbif.key_valid) begin
        v_cyc.push_back(c);
        check("t6.code", 32'(pbif.keycode), 32'd1);
      end
      if (c == 9) begin
        pbif.pb[1] = 1'b0;
        released = 1'b1;
      end else if (released && !repressed && pbif.pb_level == '0) begin
        pbif.pb[1] = 1'b1;
        repressed = 1'b1;
      end
    end
    check("t6.repressed", 32'(repressed), 32'd1);
    check("t6.count", v_cyc.size(), 32'd2);
    if (v_cyc.size() == 2) begin
      check("t6.first_at", v_cyc[0], 32'd6);
      check("t6.gap_ge12", 32'(v_cyc[1] - v_cyc[0] >= 12), 32'd1);
    end
    pbif.pb = '0;
    tick(10);
    check("t6.busy_end", 32'(pbif.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
